// File: rtl/core_pkg.sv
// Shared core definitions: architectural register file geometry and the decoder payload layout
// so decoder, operand read and execute agree on PAYLOAD_W.
package core_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int NUM_ARCH_REGS = 32;

    localparam int RD_TYPE_W   = 2;
    localparam int RD_W        = REG_IDX_W;
    localparam int EXE_UNIT_W  = 4;
    localparam int FUNC_CODE_W = 8;
    localparam int FUNC3_W     = 3;
    localparam int FUNC2_W     = 2;
    localparam int ENDSIM_W    = 1;
    localparam int AUIPC_W     = 1;
    localparam int SID_W       = 6;

    localparam int RD_TYPE_OFF   = 0;
    localparam int RD_OFF        = RD_TYPE_OFF + RD_TYPE_W;
    localparam int EXE_UNIT_OFF  = RD_OFF + RD_W;
    localparam int FUNC_CODE_OFF = EXE_UNIT_OFF + EXE_UNIT_W;
    localparam int FUNC3_OFF     = FUNC_CODE_OFF + FUNC_CODE_W;
    localparam int FUNC2_OFF     = FUNC3_OFF + FUNC3_W;
    localparam int ENDSIM_OFF    = FUNC2_OFF + FUNC2_W;
    localparam int AUIPC_OFF     = ENDSIM_OFF + ENDSIM_W;
    localparam int SID_OFF       = AUIPC_OFF + AUIPC_W;
    localparam int PAYLOAD_W     = SID_OFF + SID_W;

    // Packed MSB-first, so rd_type lands at bit 0.
    typedef struct packed {
        logic [SID_W-1:0]       sid;
        logic                   auipc;
        logic                   endsim;
        logic [FUNC2_W-1:0]     func2;
        logic [FUNC3_W-1:0]     func3;
        logic [FUNC_CODE_W-1:0] func_code;
        logic [EXE_UNIT_W-1:0]  h_exe_unit;
        logic [RD_W-1:0]        rd;
        logic [RD_TYPE_W-1:0]   rd_type;
    } payload_t;

endpackage

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with same-cycle writeback forwarding on every read port.
// x0 is hardwired to zero; the highest-index write port wins on an index conflict.
module regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NRD  = 6,
    parameter int NWR  = 2
) (
    input  logic                           clk,
    input  logic [NWR-1:0]                 wr_en,
    input  logic [NWR-1:0][REG_IDX_W-1:0]  wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]       wr_data,
    input  logic [NRD-1:0][REG_IDX_W-1:0]  rd_addr,
    output logic [NRD-1:0][XLEN-1:0]       rd_data,
    output logic [NRD-1:0]                 rd_hit
);

    logic [XLEN-1:0] mem [NUM_ARCH_REGS];

    // Later non-blocking writes override earlier ones, giving the higher port priority.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w] != '0)
                mem[wr_addr[w]] <= wr_data[w];
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_hit[r]  = 1'b0;
            rd_data[r] = mem[rd_addr[r]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w] == rd_addr[r]) begin
                    rd_hit[r]  = 1'b1;
                    rd_data[r] = wr_data[w];
                end
            end
            if (rd_addr[r] == '0) begin
                rd_hit[r]  = 1'b0;
                rd_data[r] = '0;
            end
        end
    end

endmodule

// File: rtl/operand_read_stage.sv
// Operand read stage: registers decoded lanes, reads forwarded operands and refreshes
// operands of stalled lanes from writeback.
module operand_read_stage
    import core_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int NSRC      = 3,
    parameter int XLEN      = 64,
    parameter int NWB       = 2,
    parameter int PAYLOAD_W = core_pkg::PAYLOAD_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_i,
    input  logic [LANES-1:0]                        stall_i,
    input  logic [LANES-1:0]                        dec_valid_i,
    input  logic [LANES*NSRC-1:0]                   dec_rs_valid_i,
    input  logic [LANES*NSRC-1:0][REG_IDX_W-1:0]    dec_rs_i,
    input  logic [LANES-1:0][PAYLOAD_W-1:0]         dec_payload_i,
    input  logic [NWB-1:0]                          wb_valid_i,
    input  logic [NWB-1:0][REG_IDX_W-1:0]           wb_rd_i,
    input  logic [NWB-1:0][XLEN-1:0]                wb_value_i,
    output logic [LANES-1:0]                        opr_valid_o,
    output logic [LANES*NSRC-1:0]                   opr_rs_valid_o,
    output logic [LANES*NSRC-1:0][REG_IDX_W-1:0]    opr_rs_o,
    output logic [LANES*NSRC-1:0][XLEN-1:0]         opr_rs_value_o,
    output logic [LANES-1:0][PAYLOAD_W-1:0]         opr_payload_o
);

    localparam int NRD = LANES * NSRC;

    logic [NRD-1:0][REG_IDX_W-1:0] rd_addr;
    logic [NRD-1:0][XLEN-1:0]      rd_data;
    logic [NRD-1:0]                rd_hit;

    // A stalled lane looks up its held index so the same port serves the refresh.
    for (genvar i = 0; i < NRD; i++) begin : g_addr
        assign rd_addr[i] = stall_i[i/NSRC] ? opr_rs_o[i] : dec_rs_i[i];
    end

    regfile_mp #(
        .XLEN (XLEN),
        .NRD  (NRD),
        .NWR  (NWB)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wb_valid_i),
        .wr_addr (wb_rd_i),
        .wr_data (wb_value_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            opr_valid_o    <= '0;
            opr_rs_valid_o <= '0;
            opr_rs_o       <= '0;
            opr_rs_value_o <= '0;
            opr_payload_o  <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (flush_i) begin
                    opr_valid_o[l] <= 1'b0;
                end else if (!stall_i[l]) begin
                    opr_valid_o[l]   <= dec_valid_i[l];
                    opr_payload_o[l] <= dec_payload_i[l];
                    for (int s = 0; s < NSRC; s++) begin
                        opr_rs_valid_o[l*NSRC+s] <= dec_rs_valid_i[l*NSRC+s];
                        opr_rs_o[l*NSRC+s]       <= dec_rs_i[l*NSRC+s];
                        opr_rs_value_o[l*NSRC+s] <= dec_rs_valid_i[l*NSRC+s] ?
                                                    rd_data[l*NSRC+s] : '0;
                    end
                end else begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (opr_rs_valid_o[l*NSRC+s] && rd_hit[l*NSRC+s])
                            opr_rs_value_o[l*NSRC+s] <= rd_data[l*NSRC+s];
                    end
                end
            end
        end
    end

endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Parametrised operand-read pipeline stage between the decoder and execute units. It replaces the fixed dual-lane operand stage. It registers up to `LANES` decoded instructions and reads `NSRC` source operands per lane from an integrated multi-port register file. Values are forwarded from `NWB` same-cycle writeback ports, and an instruction held by a stall has its operand values refreshed from writeback. Per-lane stall and a global flush give the same pipeline-control model as the rest of the core.

## Interface
Clock `clk`, reset `rst`; reset is synchronous and active-high.

Parameters:
- `LANES`, 2, issue lanes.
- `NSRC`, 3, source operands per lane (rs1..rs3).
- `XLEN`, 64, register width.
- `NWB`, 2, writeback ports.
- `PAYLOAD_W`, 32, opaque per-lane payload (rd_type, rd, h_exe_unit, func_code, func3, func2, endsim, auipc, sid).

Ports (lane l, source s: flat index l*NSRC+s; fields packed LSB-first):
- `clk` in 1 — clock
- `rst` in 1 — synchronous active-high reset
- `flush_i` in 1 — kill all lanes
- `stall_i` in LANES — per-lane hold from scoreboard
- `dec_valid_i` in LANES — decoder lane valid
- `dec_rs_valid_i` in LANES*NSRC — source used
- `dec_rs_i` in LANES*NSRC*5 — source register index
- `dec_payload_i` in LANES*PAYLOAD_W — pass-through fields
- `wb_valid_i` in NWB — writeback enable
- `wb_rd_i` in NWB*5 — writeback index
- `wb_value_i` in NWB*XLEN — writeback data
- `opr_valid_o` out LANES — lane valid to execute
- `opr_rs_valid_o` out LANES*NSRC — registered source-used flags
- `opr_rs_o` out LANES*NSRC*5 — registered source indices
- `opr_rs_value_o` out LANES*NSRC*XLEN — operand values
- `opr_payload_o` out LANES*PAYLOAD_W — registered payload

## Operation
- **Register file.** 32 x XLEN entries. x0 reads 0 and ignores writes. There are `LANES*NSRC` combinational read ports. All NWB writes commit at the clock edge.
- **Write conflict.** When several writeback ports target the same rd in one cycle, the highest-index port wins, for both the regfile write and forwarding.
- **Forwarded read.** Each source produces `fwd(rs)`:
  - 0 if rs==0;
  - otherwise the winning same-cycle writeback value if any valid port's `wb_rd` equals rs;
  - otherwise the regfile content.
- **Per-lane update, in priority order:**
  - `rst`: valid, rs_valid, rs, values and payload all become 0.
  - `flush_i`: valid becomes 0; other fields are don't-care (the stall is ignored).
  - `!stall_i[l]`: capture `dec_valid`, `rs_valid`, `rs` and `payload`. Each value captures `fwd(rs)` when rs_valid=1, else 0.
  - `stall_i[l]`: all fields hold, except the refresh rule below.
- **Refresh.** While a lane is stalled, each held source with rs_valid=1 and rs!=0 that matches a valid writeback this cycle loads the winning writeback value. This is applied whether or not the lane is valid.
- **Lane independence.** Lanes are fully independent. Stalling lane 0 does not stall lane 1; cross-lane ordering belongs to the scoreboard.
- **Decoder contract.** The decoder must hold its lane inputs stable while that lane is stalled. This block has no ready output.

## Timing
- Latency is 1 cycle, decoder to `opr_*`. All outputs are registered and there is no combinational input-to-output path.
- A writeback in cycle N is visible to a capture or refresh at the edge ending cycle N.
- Reset mid-operation clears everything at the next edge, including stalled lanes.
- Flush and stall asserted together: valid is 0 after the edge.
- Flush does not block regfile writes in the same cycle.
- A writeback to x0 is ignored everywhere; a source with rs=0 always yields 0.

## Structure
- Shared package `core_pkg` holds:
  - `REG_IDX_W`=5 and `NUM_ARCH_REGS`=32;
  - the payload field widths and offsets, so decoder, this stage and execute agree on `PAYLOAD_W`.
- One sub-module, `regfile_mp`, parametrised on XLEN, read-port count and write-port count. It implements the storage, the x0 rule and the write-priority rule, and supplies the forwarding mux helper.
- The top level contains the lane pipeline registers and the refresh logic.

## Test plan
1. **Reset.** Assert rst with decoder inputs active → after the edge, all outputs are 0.
2. **Same-cycle forwarding.** Lane0 rs1=5, rs_valid=1; wb0 writes x5=0xAAAA in the same cycle → next cycle `opr_rs_value` = 0xAAAA. A later read of x5 with no writeback also returns 0xAAAA.
3. **Refresh under stall.** Lane1 held with stall=1 and rs2=7 (old value 0x1). wb1 writes x7=0xBEEF → next cycle lane1 rs2 value = 0xBEEF, with valid and payload unchanged. Lane0 keeps flowing throughout.
4. **Write priority.** wb0 and wb1 both write x3, with 0x11 and 0x22, while lane0 reads rs1=3 → captured value is 0x22, and the regfile holds 0x22.
5. **x0 handling.** wb0 writes x0=0xFFFF while a source reads rs=0 → value is 0; a later read of x0 is still 0.
6. **Flush priority.** flush_i=1 with stall_i=2'b01 and both decoder lanes valid → `opr_valid_o`=2'b00 next cycle. With flush deasserted one cycle later, the following valid input appears after exactly 1 cycle.
